// File: rtl/multiplicador_pkg.sv
// Shared types and constants for the operand-capture front end of the multiplier.
package multiplicador_pkg;

    localparam int ANCHO_DEFECTO = 4;

    typedef enum logic [1:0] {
        ESPERA   = 2'b00,
        PRESENTA = 2'b01,
        OCUPADO  = 2'b10
    } estado_lectura_t;

endpackage

// File: rtl/antirrebote.sv
// Start-button conditioning: multi-flop synchroniser, stability counter and
// a registered one-cycle pulse on each accepted rising level.
module antirrebote #(
    parameter int SINC_ETAPAS        = 2,
    parameter int ANTIRREBOTE_CICLOS = 16
) (
    input  logic reloj,
    input  logic reinicio,
    input  logic entrada,
    output logic nivel,
    output logic pulso
);

    localparam int CW = (ANTIRREBOTE_CICLOS > 1) ? $clog2(ANTIRREBOTE_CICLOS) : 1;
    localparam logic [CW-1:0] CUENTA_MAX = CW'(ANTIRREBOTE_CICLOS - 1);

    logic [SINC_ETAPAS-1:0] r_sinc;
    logic [CW-1:0]          r_cuenta;
    logic                   r_nivel;
    logic                   r_nivel_d;
    logic                   r_pulso;
    logic                   w_muestra;
    logic [CW-1:0]          w_cuenta_sig;
    logic                   w_nivel_sig;

    assign w_muestra = r_sinc[SINC_ETAPAS-1];

    // Synchroniser chain for the asynchronous button
    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            r_sinc <= {SINC_ETAPAS{1'b0}};
        end else begin
            r_sinc <= {r_sinc[SINC_ETAPAS-2:0], entrada};
        end
    end

    // The level only flips after ANTIRREBOTE_CICLOS consecutive disagreeing samples
    always_comb begin
        w_cuenta_sig = {CW{1'b0}};
        w_nivel_sig  = r_nivel;
        if (w_muestra == r_nivel) begin
            w_cuenta_sig = {CW{1'b0}};
            w_nivel_sig  = r_nivel;
        end else if (r_cuenta == CUENTA_MAX) begin
            w_cuenta_sig = {CW{1'b0}};
            w_nivel_sig  = ~r_nivel;
        end else begin
            w_cuenta_sig = r_cuenta + CW'(1);
            w_nivel_sig  = r_nivel;
        end
    end

    // Counter, debounced level and rising-edge pulse registers
    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            r_cuenta  <= {CW{1'b0}};
            r_nivel   <= 1'b0;
            r_nivel_d <= 1'b0;
            r_pulso   <= 1'b0;
        end else begin
            r_cuenta  <= w_cuenta_sig;
            r_nivel   <= w_nivel_sig;
            r_nivel_d <= r_nivel;
            r_pulso   <= r_nivel & ~r_nivel_d;
        end
    end

    assign nivel = r_nivel;
    assign pulso = r_pulso;

endmodule

// File: rtl/captura_operandos.sv
// Captures two switch operands on a debounced button press and offers them
// to the multiplier over valid/ready, blocking new captures until it finishes.
module captura_operandos
    import multiplicador_pkg::*;
#(
    parameter int ANCHO              = ANCHO_DEFECTO,
    parameter int SINC_ETAPAS        = 2,
    parameter int ANTIRREBOTE_CICLOS = 16
) (
    input  logic             reloj,
    input  logic             reinicio,
    input  logic [ANCHO-1:0] operandoEntradaA,
    input  logic [ANCHO-1:0] operandoEntradaB,
    input  logic             iniciarMultiplicacion,
    input  logic             multiplicadorListo,
    input  logic             finMultiplicacion,
    output logic [ANCHO-1:0] operandoSalidaA,
    output logic [ANCHO-1:0] operandoSalidaB,
    output logic             banderaValida,
    output logic             ocupado,
    output logic             ledOperandoA,
    output logic             ledOperandoB
);

    estado_lectura_t  r_estado;
    estado_lectura_t  w_estado_sig;
    logic [ANCHO-1:0] r_a;
    logic [ANCHO-1:0] r_b;
    logic [ANCHO-1:0] w_a_sig;
    logic [ANCHO-1:0] w_b_sig;
    logic             r_valida;
    logic             r_ocupado;
    logic             r_led;
    logic             w_valida_sig;
    logic             w_ocupado_sig;
    logic             w_led_sig;
    logic             w_pulso;
    logic             w_nivel_unused;

    antirrebote #(
        .SINC_ETAPAS        (SINC_ETAPAS),
        .ANTIRREBOTE_CICLOS (ANTIRREBOTE_CICLOS)
    ) u_antirrebote (
        .reloj    (reloj),
        .reinicio (reinicio),
        .entrada  (iniciarMultiplicacion),
        .nivel    (w_nivel_unused),
        .pulso    (w_pulso)
    );

    // Next state and next operand values; presses outside ESPERA are dropped
    always_comb begin
        w_estado_sig = r_estado;
        w_a_sig      = r_a;
        w_b_sig      = r_b;
        case (r_estado)
            ESPERA: begin
                if (w_pulso) begin
                    w_estado_sig = PRESENTA;
                    w_a_sig      = operandoEntradaA;
                    w_b_sig      = operandoEntradaB;
                end else begin
                    w_estado_sig = ESPERA;
                end
            end
            PRESENTA: begin
                if (r_valida && multiplicadorListo) begin
                    w_estado_sig = OCUPADO;
                end else begin
                    w_estado_sig = PRESENTA;
                end
            end
            OCUPADO: begin
                if (finMultiplicacion) begin
                    w_estado_sig = ESPERA;
                    w_a_sig      = {ANCHO{1'b0}};
                    w_b_sig      = {ANCHO{1'b0}};
                end else begin
                    w_estado_sig = OCUPADO;
                end
            end
            default: begin
                w_estado_sig = ESPERA;
                w_a_sig      = {ANCHO{1'b0}};
                w_b_sig      = {ANCHO{1'b0}};
            end
        endcase
    end

    // Flag outputs are decoded from the next state so they register alongside it
    always_comb begin
        w_valida_sig  = (w_estado_sig == PRESENTA);
        w_ocupado_sig = (w_estado_sig != ESPERA);
        w_led_sig     = (w_estado_sig == ESPERA);
    end

    // State and output registers
    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            r_estado  <= ESPERA;
            r_a       <= {ANCHO{1'b0}};
            r_b       <= {ANCHO{1'b0}};
            r_valida  <= 1'b0;
            r_ocupado <= 1'b0;
            r_led     <= 1'b1;
        end else begin
            r_estado  <= w_estado_sig;
            r_a       <= w_a_sig;
            r_b       <= w_b_sig;
            r_valida  <= w_valida_sig;
            r_ocupado <= w_ocupado_sig;
            r_led     <= w_led_sig;
        end
    end

    assign operandoSalidaA = r_a;
    assign operandoSalidaB = r_b;
    assign banderaValida   = r_valida;
    assign ocupado         = r_ocupado;
    assign ledOperandoA    = r_led;
    assign ledOperandoB    = r_led;

endmodule
